// File: rtl/collision_scheduler_if.sv
// Bullet-table port bundle for collision_scheduler.
// The scheduler (master) addresses one slot at a time and reads it back
// combinationally; it may also request that the addressed slot be cleared.
//
// Clear handshake: o_Clr_Req rises with o_Slot_Idx already stable and both stay
// unchanged until a rising clock edge samples i_Clr_Ack=1 while the request is
// high; that edge is the transfer. The request is low in the cycle after the
// transfer. i_Clr_Ack sampled while no request is pending has no effect, and
// an ack in the first request cycle is legal.
interface collision_scheduler_if #(
    parameter int IDX_W = 3
);
    logic [IDX_W-1:0] o_Slot_Idx;
    logic             i_Slot_Valid;
    logic [4:0]       i_Slot_x;
    logic [5:0]       i_Slot_y;
    logic             o_Clr_Req;
    logic             i_Clr_Ack;

    // Scheduler side
    modport master (
        output o_Slot_Idx,
        output o_Clr_Req,
        input  i_Slot_Valid,
        input  i_Slot_x,
        input  i_Slot_y,
        input  i_Clr_Ack
    );

    // Bullet-table side
    modport slave (
        input  o_Slot_Idx,
        input  o_Clr_Req,
        output i_Slot_Valid,
        output i_Slot_x,
        output i_Slot_y,
        output i_Clr_Ack
    );
endinterface

// File: rtl/collision_scheduler.sv
// Frame-rate player / enemy-bullet collision scheduler.
// Once per frame tick it walks every bullet slot (one per clock) against the
// player position latched at the tick, asks the bullet table to clear each hit
// bullet, and maintains lives, post-hit invulnerability and game-over.
// o_Dbg_State exposes the scan FSM: 0 IDLE, 1 SCAN, 2 CLEAR, 3 DONE.
module collision_scheduler #(
    parameter int FRAME_CYCLES  = 800_000,
    parameter int NUM_SLOTS     = 8,
    parameter int IDX_W         = 3,
    parameter int INIT_LIVES    = 3,
    parameter int INVULN_FRAMES = 2
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Enable,
    input  logic [4:0]           i_Plyer_x,
    input  logic [5:0]           i_Plyer_y,
    collision_scheduler_if.master bt,
    output logic                 o_Hit,
    output logic [2:0]           o_Lives,
    output logic                 o_Game_Over,
    output logic                 o_Frame_Done,
    output logic                 o_Overrun,
    output logic [1:0]           o_Dbg_State
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int INV_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_SLOTS - 1);
    localparam logic [INV_W-1:0] INV_LOAD   = INV_W'(INVULN_FRAMES);
    localparam logic [2:0]       LIVES_INIT = 3'(INIT_LIVES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [4:0]       px_q;
    logic [5:0]       py_q;
    logic             clr_req_q;
    logic             frame_done_q;
    logic             overrun_q;
    logic             hit_q;
    logic [2:0]       lives_q;
    logic             game_over_q;
    logic [INV_W-1:0] inv_q;
    logic             inv_loaded_q;   // invulnerability (re)loaded during this frame
    logic             lost_q;         // a life has already been taken this frame

    logic tick;
    logic slot_match;
    logic idx_last;
    logic take_life;
    logic ev_start;
    logic ev_match;
    logic ev_done;

    // The tick is a single cycle wide because the counter wraps on that same edge.
    assign tick       = i_Enable && (cnt_q == CNT_LAST);
    assign slot_match = bt.i_Slot_Valid && (bt.i_Slot_x == px_q) && (bt.i_Slot_y == py_q);
    assign idx_last   = (idx_q == IDX_LAST);
    assign take_life  = (inv_q == '0) && !lost_q && (lives_q != 3'd0);

    assign ev_start = (state_q == ST_IDLE) && tick && !game_over_q;
    assign ev_match = (state_q == ST_SCAN) && slot_match;
    assign ev_done  = (state_q == ST_DONE);

    // Frame counter: counts while enabled, holds its value while disabled.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else if (i_Enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Scan FSM: slot walk, clear request, latched player position, end-of-scan pulse.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
            clr_req_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ev_start) begin
                        state_q <= ST_SCAN;
                        idx_q   <= '0;
                        px_q    <= i_Plyer_x;
                        py_q    <= i_Plyer_y;
                    end
                end
                ST_SCAN: begin
                    if (slot_match) begin
                        state_q   <= ST_CLEAR;
                        clr_req_q <= 1'b1;
                    end else if (idx_last) begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_CLEAR: begin
                    // Address stays put until the table takes the clear.
                    if (bt.i_Clr_Ack) begin
                        clr_req_q <= 1'b0;
                        if (idx_last) begin
                            state_q      <= ST_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_SCAN;
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Lives, hit pulse, invulnerability and game-over bookkeeping.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hit_q        <= 1'b0;
            lives_q      <= LIVES_INIT;
            game_over_q  <= 1'b0;
            inv_q        <= '0;
            inv_loaded_q <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (ev_start) begin
                lost_q       <= 1'b0;
                inv_loaded_q <= 1'b0;
            end
            if (ev_match && take_life) begin
                lives_q      <= lives_q - 3'd1;
                hit_q        <= 1'b1;
                lost_q       <= 1'b1;
                inv_q        <= INV_LOAD;
                inv_loaded_q <= 1'b1;
                if (lives_q == 3'd1) begin
                    game_over_q <= 1'b1;
                end
            end
            // A frame that loaded invulnerability does not also count it down.
            if (ev_done && (inv_q != '0) && !inv_loaded_q) begin
                inv_q <= inv_q - INV_W'(1);
            end
        end
    end

    // Sticky overrun: a tick that finds the scan still busy is dropped, not queued.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            overrun_q <= 1'b0;
        end else if (tick && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
        end
    end

    // The clear request is withdrawn as soon as reset is asserted, not one edge later.
    assign bt.o_Clr_Req  = clr_req_q && !i_Rst;
    assign bt.o_Slot_Idx = idx_q;

    assign o_Hit        = hit_q;
    assign o_Lives      = lives_q;
    assign o_Game_Over  = game_over_q;
    assign o_Frame_Done = frame_done_q;
    assign o_Overrun    = overrun_q;
    assign o_Dbg_State  = state_q;

endmodule
